// File: rtl/mux_pkg.sv
// Shared limits and helpers for the pipelined N:1 operand selector.
// Imported by the top and by the per-stage register slice.
package mux_pkg;

    localparam int MUX_MAX_IN     = 16;
    localparam int MUX_MAX_STAGES = 4;

    function automatic logic sel_is_legal(input int unsigned sel, input int unsigned num_in);
        return sel < num_in;
    endfunction

endpackage

// File: rtl/pipe_slice.sv
// One elastic register stage: captures {valid, err, data} when load is high.
// An empty stage keeps its old payload, so only the valid bit needs clearing on flush.
module pipe_slice
    import mux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic             d_valid,
    input  logic             d_err,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic             q_err,
    output logic [WIDTH-1:0] q_data
);

    typedef struct packed {
        logic             valid;
        logic             err;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t entry_q;
    entry_t entry_d;

    always_comb begin
        entry_d = entry_q;
        if (flush) begin
            entry_d.valid = 1'b0;
        end else if (load) begin
            entry_d.valid = d_valid;
            if (d_valid) begin
                entry_d.err  = d_err;
                entry_d.data = d_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q_valid = entry_q.valid;
    assign q_err   = entry_q.err;
    assign q_data  = entry_q.data;

endmodule

// File: rtl/mux_nx1_pipe.sv
// N:1 forwarding-operand selector followed by a STAGES-deep elastic valid/ready pipeline.
// Out-of-range selects yield zero data with an error flag and bump a saturating counter.
module mux_nx1_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 3,
    parameter  int STAGES = 1,
    parameter  int CNT_W  = 16,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err,
    output logic [CNT_W-1:0]        err_count
);

    if (NUM_IN < 2 || NUM_IN > MUX_MAX_IN) begin : g_bad_num_in
        $error("mux_nx1_pipe: NUM_IN=%0d outside 2..%0d", NUM_IN, MUX_MAX_IN);
    end
    if (STAGES < 1 || STAGES > MUX_MAX_STAGES) begin : g_bad_stages
        $error("mux_nx1_pipe: STAGES=%0d outside 1..%0d", STAGES, MUX_MAX_STAGES);
    end

    logic [WIDTH-1:0]  mux_data;
    logic              mux_err;
    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_err;
    logic [STAGES-1:0] stage_load;
    logic [WIDTH-1:0]  stage_data [STAGES];
    logic [CNT_W-1:0]  err_count_q;
    logic [CNT_W-1:0]  err_count_d;

    always_comb begin
        mux_data = '0;
        mux_err  = !sel_is_legal(32'(sel), NUM_IN);
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                mux_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A stage may load if any stage at or below it is empty or the sink is taking data,
    // which is what lets bubbles collapse instead of stalling the whole chain.
    always_comb begin : ready_chain
        logic room;
        room       = out_ready;
        stage_load = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            room          = room | ~stage_valid[k];
            stage_load[k] = room;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             d_valid;
        logic             d_err;
        logic [WIDTH-1:0] d_data;

        if (k == 0) begin : g_head
            assign d_valid = in_valid;
            assign d_err   = mux_err;
            assign d_data  = mux_data;
        end else begin : g_body
            assign d_valid = stage_valid[k-1];
            assign d_err   = stage_err[k-1];
            assign d_data  = stage_data[k-1];
        end

        pipe_slice #(
            .WIDTH (WIDTH)
        ) u_slice (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .load    (stage_load[k]),
            .d_valid (d_valid),
            .d_err   (d_err),
            .d_data  (d_data),
            .q_valid (stage_valid[k]),
            .q_err   (stage_err[k]),
            .q_data  (stage_data[k])
        );
    end

    assign in_ready    = stage_load[0] & ~flush;
    assign out_valid   = stage_valid[STAGES-1];
    assign out_sel_err = stage_err[STAGES-1];
    assign out_data    = stage_data[STAGES-1];

    // Only accepted transfers count; flush forces in_ready low so dropped inputs never do.
    always_comb begin
        err_count_d = err_count_q;
        if (in_valid && in_ready && mux_err && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Scoreboard bench: a 3-input/2-stage instance for directed cases and an
// 8-input/64-bit/4-stage instance driven with random traffic.
module tb_mux_nx1_pipe;

   localparam int A_W = 32;
   localparam int A_N = 3;
   localparam int A_S = 2;
   localparam int A_C = 16;
   localparam int B_W = 64;
   localparam int B_N = 8;
   localparam int B_S = 4;
   localparam int B_C = 16;

   typedef struct {
      logic [63:0] data;
      logic        err;
      longint      edgeN;
      bit          lat;
   } sb_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   longint cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   logic               a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sel_err;
   logic [A_N*A_W-1:0] a_in_data;
   logic [1:0]         a_sel;
   logic [A_W-1:0]     a_out_data;
   logic [A_C-1:0]     a_err_count;

   logic               b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sel_err;
   logic [B_N*B_W-1:0] b_in_data;
   logic [2:0]         b_sel;
   logic [B_W-1:0]     b_out_data;
   logic [B_C-1:0]     b_err_count;

   mux_nx1_pipe #(.WIDTH(A_W), .NUM_IN(A_N), .STAGES(A_S), .CNT_W(A_C)) dut_a (
      .clk(clk), .rst(a_rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .sel(a_sel), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_data(a_out_data), .out_sel_err(a_out_sel_err), .err_count(a_err_count));

   mux_nx1_pipe #(.WIDTH(B_W), .NUM_IN(B_N), .STAGES(B_S), .CNT_W(B_C)) dut_b (
      .clk(clk), .rst(b_rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .sel(b_sel), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .out_sel_err(b_out_sel_err), .err_count(b_err_count));

   sb_t    qa[$];
   sb_t    qb[$];
   bit     aLat = 1'b0;
   bit     bLat = 1'b0;

   // Single comparison point: every check in the bench funnels through here.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic timeoutNote(input string name);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: got no handshake, expected one within budget at t=%0t", name, $time);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor for instance A: decides at the falling edge which transfers the next rising
   // edge will perform, checks outputs against the queue head, then updates the model.
   initial begin : monA
      sb_t         e;
      longint      cntM;
      bit          hold;
      logic [31:0] holdData;
      logic        holdErr;
      cntM = 0;
      hold = 1'b0;
      holdData = '0;
      holdErr = 1'b0;
      forever begin
         @(negedge clk);
         if (a_rst) begin
            qa.delete();
            cntM = 0;
         end else begin
            checkOutput("a_in_ready", 64'(a_in_ready), 64'(!a_flush && (qa.size() < A_S || a_out_ready)));
            checkOutput("a_err_count", 64'(a_err_count), 64'(cntM));
            if (hold) begin
               checkOutput("a_hold_valid", 64'(a_out_valid), 64'd1);
               checkOutput("a_hold_data", 64'(a_out_data), 64'(holdData));
               checkOutput("a_hold_err", 64'(a_out_sel_err), 64'(holdErr));
            end
            if (a_out_valid && a_out_ready) begin
               if (qa.size() == 0) begin
                  timeoutNote("a_spurious_output");
               end else begin
                  e = qa.pop_front();
                  checkOutput("a_out_data", 64'(a_out_data), e.data);
                  checkOutput("a_out_sel_err", 64'(a_out_sel_err), 64'(e.err));
                  if (e.lat && aLat) checkOutput("a_latency", 64'(cyc + 1 - e.edgeN), 64'(A_S));
               end
            end
            if (a_flush) qa.delete();
            if (a_in_valid && a_in_ready) begin
               e.err   = (int'(a_sel) >= A_N);
               e.data  = '0;
               if (!e.err) e.data = 64'(a_in_data[int'(a_sel)*A_W +: A_W]);
               e.edgeN = cyc + 1;
               e.lat   = aLat;
               qa.push_back(e);
               if (e.err && cntM < (2**A_C - 1)) cntM++;
            end
         end
         hold     = !a_rst && !a_flush && a_out_valid && !a_out_ready;
         holdData = a_out_data;
         holdErr  = a_out_sel_err;
      end
   end

   // Same scoreboard rules for instance B.
   initial begin : monB
      sb_t         e;
      longint      cntM;
      bit          hold;
      logic [63:0] holdData;
      logic        holdErr;
      cntM = 0;
      hold = 1'b0;
      holdData = '0;
      holdErr = 1'b0;
      forever begin
         @(negedge clk);
         if (b_rst) begin
            qb.delete();
            cntM = 0;
         end else begin
            checkOutput("b_in_ready", 64'(b_in_ready), 64'(!b_flush && (qb.size() < B_S || b_out_ready)));
            checkOutput("b_err_count", 64'(b_err_count), 64'(cntM));
            if (hold) begin
               checkOutput("b_hold_valid", 64'(b_out_valid), 64'd1);
               checkOutput("b_hold_data", b_out_data, holdData);
               checkOutput("b_hold_err", 64'(b_out_sel_err), 64'(holdErr));
            end
            if (b_out_valid && b_out_ready) begin
               if (qb.size() == 0) begin
                  timeoutNote("b_spurious_output");
               end else begin
                  e = qb.pop_front();
                  checkOutput("b_out_data", b_out_data, e.data);
                  checkOutput("b_out_sel_err", 64'(b_out_sel_err), 64'(e.err));
                  if (e.lat && bLat) checkOutput("b_latency", 64'(cyc + 1 - e.edgeN), 64'(B_S));
               end
            end
            if (b_flush) qb.delete();
            if (b_in_valid && b_in_ready) begin
               e.err   = (int'(b_sel) >= B_N);
               e.data  = '0;
               if (!e.err) e.data = b_in_data[int'(b_sel)*B_W +: B_W];
               e.edgeN = cyc + 1;
               e.lat   = bLat;
               qb.push_back(e);
               if (e.err && cntM < (2**B_C - 1)) cntM++;
            end
         end
         hold     = !b_rst && !b_flush && b_out_valid && !b_out_ready;
         holdData = b_out_data;
         holdErr  = b_out_sel_err;
      end
   end

   // Presents one item to instance A and waits (bounded) until it is accepted.
   // Entered and left just after a rising edge.
   task automatic applyStimulus(input logic [1:0] sel, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input int budget);
      bit accepted;
      accepted   = 1'b0;
      a_sel      = sel;
      a_in_data  = {w2, w1, w0};
      a_in_valid = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (a_in_ready) begin
            accepted = 1'b1;
            break;
         end
      end
      if (!accepted) timeoutNote("a_accept");
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic resetA();
      a_rst = 1'b1;
      @(posedge clk);
      #1;
      a_rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stim
      bit drained;
      a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_data = '0; a_sel = '0;
      b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_data = '0; b_sel = '0;
      repeat (3) @(posedge clk);
      #1;
      a_rst = 1'b0;
      b_rst = 1'b0;

      // Reset state of both instances.
      @(negedge clk);
      checkOutput("rst_a_out_valid", 64'(a_out_valid), 64'd0);
      checkOutput("rst_a_out_data", 64'(a_out_data), 64'd0);
      checkOutput("rst_a_out_sel_err", 64'(a_out_sel_err), 64'd0);
      checkOutput("rst_a_err_count", 64'(a_err_count), 64'd0);
      checkOutput("rst_b_out_valid", 64'(b_out_valid), 64'd0);
      checkOutput("rst_b_out_data", b_out_data, 64'd0);
      @(posedge clk);
      #1;

      $display("[TB] in-order selection and latency");
      aLat = 1'b1;
      applyStimulus(2'd0, 32'hA, 32'hB, 32'hC, 2);
      applyStimulus(2'd1, 32'hA, 32'hB, 32'hC, 2);
      applyStimulus(2'd2, 32'hA, 32'hB, 32'hC, 2);
      idleCycles(4);

      $display("[TB] illegal select and counter saturation");
      applyStimulus(2'd3, 32'h1111, 32'h2222, 32'h3333, 2);
      idleCycles(3);
      checkOutput("t2_err_count_one", 64'(a_err_count), 64'd1);
      aLat = 1'b0;
      a_sel = 2'd3;
      a_in_data = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001};
      a_in_valid = 1'b1;
      repeat (65540) @(posedge clk);
      #1;
      a_in_valid = 1'b0;
      idleCycles(3);
      checkOutput("t2_err_count_sat", 64'(a_err_count), 64'h0000_0000_0000_FFFF);

      $display("[TB] back-pressure");
      resetA();
      a_out_ready = 1'b0;
      applyStimulus(2'd0, $urandom, $urandom, $urandom, 2);
      applyStimulus(2'd1, $urandom, $urandom, $urandom, 2);
      a_sel = 2'd2;
      a_in_data = {32'h0BAD_F00D, 32'h1, 32'h2};
      a_in_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checkOutput("t3_in_ready_low", 64'(a_in_ready), 64'd0);
         checkOutput("t3_out_valid_held", 64'(a_out_valid), 64'd1);
      end
      @(posedge clk);
      #1;
      a_out_ready = 1'b1;
      applyStimulus(2'd2, 32'h2, 32'h1, 32'h0BAD_F00D, 4);
      idleCycles(6);
      checkOutput("t3_all_delivered", 64'(qa.size()), 64'd0);

      $display("[TB] flush with full pipeline");
      a_out_ready = 1'b0;
      applyStimulus(2'd3, 32'h5, 32'h6, 32'h7, 2);
      applyStimulus(2'd0, 32'h8, 32'h9, 32'hA, 2);
      a_flush = 1'b1;
      a_in_valid = 1'b1;
      a_sel = 2'd3;
      a_out_ready = 1'b1;
      @(negedge clk);
      checkOutput("t4_in_ready_flush", 64'(a_in_ready), 64'd0);
      @(posedge clk);
      #1;
      a_flush = 1'b0;
      a_in_valid = 1'b0;
      @(negedge clk);
      checkOutput("t4_out_valid_after", 64'(a_out_valid), 64'd0);
      checkOutput("t4_err_count_kept", 64'(a_err_count), 64'd1);
      @(posedge clk);
      #1;
      idleCycles(4);

      $display("[TB] reset mid-stream");
      a_out_ready = 1'b0;
      applyStimulus(2'd3, 32'h11, 32'h12, 32'h13, 2);
      applyStimulus(2'd2, 32'h21, 32'h22, 32'h23, 2);
      a_in_valid = 1'b1;
      a_rst = 1'b1;
      @(posedge clk);
      #1;
      a_rst = 1'b0;
      a_in_valid = 1'b0;
      @(negedge clk);
      checkOutput("t5_out_valid", 64'(a_out_valid), 64'd0);
      checkOutput("t5_out_data", 64'(a_out_data), 64'd0);
      checkOutput("t5_out_sel_err", 64'(a_out_sel_err), 64'd0);
      checkOutput("t5_err_count", 64'(a_err_count), 64'd0);
      checkOutput("t5_in_ready", 64'(a_in_ready), 64'd1);
      @(posedge clk);
      #1;
      a_out_ready = 1'b1;

      $display("[TB] random traffic on 8x64 four-stage instance");
      bLat = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         if (c == 300) bLat = 1'b0;
         b_in_valid = ($urandom_range(0, 9) < 8);
         b_sel = 3'($urandom_range(0, 7));
         for (int i = 0; i < B_N; i++) b_in_data[i*B_W +: B_W] = {$urandom, $urandom};
         if (c >= 300) begin
            b_out_ready = ($urandom_range(0, 3) != 0);
            b_flush = ($urandom_range(0, 49) == 0);
         end
         @(posedge clk);
         #1;
      end
      b_in_valid = 1'b0;
      b_flush = 1'b0;
      b_out_ready = 1'b1;
      drained = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (qb.size() == 0 && !b_out_valid) begin
            drained = 1'b1;
            break;
         end
      end
      if (!drained) timeoutNote("b_drain");
      checkOutput("b_drain_empty", 64'(qb.size()), 64'd0);
      idleCycles(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
